// File: rtl/idex_pipeline_reg_pkg.sv
// Shared pipeline constants: control-bundle layout, datapath widths and the
// ID/EX stage record used by idex_pipeline_reg.
package idex_pipeline_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int CTRL_W     = 8;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 16;

  // Bit positions inside the 8-bit decoded control bundle.
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_REG_DST   = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_ALU_OP_HI = 1;
  localparam int CTRL_ALU_OP_LO = 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     pc4;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } idex_stage_t;

  // A load in EX whose destination (never $zero) is a source of the ID instruction.
  function automatic logic load_use_hazard(
    input logic [CTRL_W-1:0]     ex_ctrl,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] id_rs,
    input logic [REG_ADDR_W-1:0] id_rt
  );
    return ex_ctrl[CTRL_MEM_READ] && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register with flush bubbles and optional load-use stall
// detection (enabled by defining IDEX_LOAD_USE_DETECT_EN).
module idex_pipeline_reg
  import idex_pipeline_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic [CNT_W-1:0]      bubble_count
);

  idex_stage_t stage_q;
  idex_stage_t stage_d;
  idex_stage_t id_stage;
  logic        load_use;

  assign id_stage = '{
    ctrl: id_ctrl,
    pc4:  id_pc4,
    rd1:  id_rd1,
    rd2:  id_rd2,
    imm:  id_imm,
    rs:   id_rs,
    rt:   id_rt,
    rd:   id_rd
  };

`ifdef IDEX_LOAD_USE_DETECT_EN
  logic [CNT_W-1:0] bubble_count_q;
  logic [CNT_W-1:0] bubble_count_d;

  assign load_use = load_use_hazard(stage_q.ctrl, stage_q.rt, id_rs, id_rt);

  // Only load-use bubbles are counted; a coincident flush owns the bubble.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (load_use && !flush && (bubble_count_q != CNT_MAX)) begin
      bubble_count_d = bubble_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`else
  assign load_use     = 1'b0;
  assign bubble_count = '0;
`endif

  // A bubble is an all-zero stage: no writes, no memory access, $zero fields.
  always_comb begin
    stage_d = id_stage;
    if (flush || load_use) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_ctrl    = stage_q.ctrl;
  assign ex_pc4     = stage_q.pc4;
  assign ex_rd1     = stage_q.rd1;
  assign ex_rd2     = stage_q.rd2;
  assign ex_imm     = stage_q.imm;
  assign ex_rs      = stage_q.rs;
  assign ex_rt      = stage_q.rt;
  assign ex_rd      = stage_q.rd;

  assign pc_write   = !load_use;
  assign ifid_write = !load_use;

endmodule
